// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_rx_pkg;

  // Frame sequencing states. BREAK is reachable only when break detection is built in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5,
    BREAK  = 3'd6
  } state_t;

  // Edges past mid-bit at which the three-sample majority vote is complete.
  localparam int SAMPLE_OFS = 2;

endpackage

// File: rtl/uart_rx_tick_dec.sv
// Decodes the in-bit edge counter into "vote complete" and "bit end" ticks.
// Latency: purely combinational, zero cycles.
// Backpressure: none; ticks follow the counter every cycle.
module uart_rx_tick_dec
#(
  parameter int PRESC_W = 5
)(
  input  logic [PRESC_W-1:0] edge_count,
  input  logic [PRESC_W-1:0] prescale_q,
  output logic               sdone,
  output logic               bend
);
  import uart_rx_pkg::*;

  logic [PRESC_W-1:0] samp_pt;

  // Vote completes SAMPLE_OFS edges after mid-bit; bit ends on the last prescale edge.
  always_comb begin
    samp_pt = (prescale_q >> 1) + PRESC_W'(SAMPLE_OFS);
    sdone   = (edge_count == samp_pt);
    bend    = (edge_count == prescale_q);
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// Frame sequencer for the oversampled UART receiver; optional break detection via UART_RX_BREAK_DET_EN.
// Latency: strobes combinational from state/counts; data_valid/error flags one cycle after stop-bit vote.
// Backpressure: none; the serial line cannot be stalled, every frame is sequenced at line rate.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 5,
  parameter int BCNT_W  = 4
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic               par_en,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [PRESC_W-1:0] edge_count,
  input  logic [BCNT_W-1:0]  bit_count,
  input  logic               samp_bit,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic               cnt_en,
  output logic               cnt_clr,
  output logic               samp_en,
  output logic               deser_en,
  output logic               strt_chk_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               data_valid,
  output logic               par_err_o,
  output logic               frame_err,
  output logic               break_det
);

  state_t             state;
  state_t             state_d;
  logic [PRESC_W-1:0] prescale_q;
  logic               par_en_q;
  logic               perr_q;
  logic               stp_err_q;
  logic               data_valid_q;
  logic               par_err_out_q;
  logic               sdone;
  logic               bend;
  logic               data_bit;
  logic               last_data_bit;
  logic               break_c;
  logic               to_done;

`ifdef UART_RX_BREAK_DET_EN
  logic               any_one_q;
`else
  // Majority sample only feeds the break tracker, which is not built here.
  logic               unused_samp_bit;
  assign unused_samp_bit = samp_bit;
`endif

  uart_rx_tick_dec #(
    .PRESC_W (PRESC_W)
  ) u_tick_dec (
    .edge_count (edge_count),
    .prescale_q (prescale_q),
    .sdone      (sdone),
    .bend       (bend)
  );

  // Bit index 0 is the start bit, so data occupies indices 1..DATA_W.
  always_comb begin
    data_bit      = (bit_count != '0) && (bit_count <= BCNT_W'(DATA_W));
    last_data_bit = (bit_count == BCNT_W'(DATA_W));
  end

  // Next-state and strobe decode; everything forced low while reset is held.
  always_comb begin
    state_d     = state;
    cnt_en      = 1'b0;
    cnt_clr     = 1'b0;
    samp_en     = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    break_c     = 1'b0;
    to_done     = 1'b0;

    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_in) begin
          state_d = START;
        end
      end

      START: begin
        cnt_en  = 1'b1;
        samp_en = 1'b1;
        if (sdone) begin
          strt_chk_en = 1'b1;
        end
        // A start bit that votes high was noise: drop the frame silently.
        if (sdone && strt_glitch) begin
          state_d = IDLE;
        end else if (bend) begin
          state_d = DATA;
        end
      end

      DATA: begin
        cnt_en  = 1'b1;
        samp_en = 1'b1;
        if (sdone && data_bit) begin
          deser_en = 1'b1;
        end
        if (bend && last_data_bit) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end

      PARITY: begin
        cnt_en  = 1'b1;
        samp_en = 1'b1;
        if (sdone) begin
          par_chk_en = 1'b1;
        end
        if (bend) begin
          state_d = STOP;
        end
      end

      STOP: begin
        cnt_en  = 1'b1;
        samp_en = 1'b1;
        // Leave at the stop vote so the back half of the stop bit is free for re-sync.
        if (sdone) begin
          stp_chk_en = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
          if (stp_err && !any_one_q) begin
            state_d = BREAK;
          end else begin
            state_d = DONE;
            to_done = 1'b1;
          end
`else
          state_d = DONE;
          to_done = 1'b1;
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

`ifdef UART_RX_BREAK_DET_EN
      BREAK: begin
        // Hold the counter cleared until the line returns to idle high.
        cnt_clr = 1'b1;
        break_c = 1'b1;
        if (rx_in) begin
          state_d = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    if (!rst) begin
      state_d     = IDLE;
      cnt_en      = 1'b0;
      cnt_clr     = 1'b0;
      samp_en     = 1'b0;
      deser_en    = 1'b0;
      strt_chk_en = 1'b0;
      par_chk_en  = 1'b0;
      stp_chk_en  = 1'b0;
      break_c     = 1'b0;
      to_done     = 1'b0;
    end
  end

  // State register plus per-frame configuration and error capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      prescale_q    <= '0;
      par_en_q      <= 1'b0;
      perr_q        <= 1'b0;
      stp_err_q     <= 1'b0;
      data_valid_q  <= 1'b0;
      par_err_out_q <= 1'b0;
    end else begin
      state <= state_d;

      // Frame configuration is frozen from the moment the start edge is seen.
      if (state == IDLE) begin
        prescale_q <= prescale;
        par_en_q   <= par_en;
        perr_q     <= 1'b0;
      end

      if (par_chk_en) begin
        perr_q <= par_err;
      end

      // Completion flags are high exactly for the single DONE cycle.
      data_valid_q  <= 1'b0;
      par_err_out_q <= 1'b0;
      stp_err_q     <= 1'b0;
      if (to_done) begin
        data_valid_q  <= !perr_q && !stp_err;
        par_err_out_q <= perr_q;
        stp_err_q     <= stp_err;
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  // Remember whether any data bit voted high; an all-zero frame with bad stop is a break.
  always_ff @(posedge clk) begin
    if (!rst) begin
      any_one_q <= 1'b0;
    end else if (state == IDLE) begin
      any_one_q <= 1'b0;
    end else if (deser_en) begin
      any_one_q <= any_one_q | samp_bit;
    end
  end
`endif

  assign data_valid = data_valid_q  & rst;
  assign par_err_o  = par_err_out_q & rst;
  assign frame_err  = stp_err_q     & rst;
  assign break_det  = break_c;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm with behavioural counter, sampler, deserializer and checkers.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       par_en;
  logic [4:0] prescale;
  logic [4:0] ec = '0;
  logic [3:0] bcnt = '0;
  logic       samp_bit;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic       cnt_en, cnt_clr, samp_en, deser_en;
  logic       strt_chk_en, par_chk_en, stp_chk_en;
  logic       data_valid, par_err_o, frame_err, break_det;

  logic [7:0] shreg = '0;
  logic [4:0] cur_presc = 5'd7;
  logic [7:0] last_data = '0;
  logic [7:0] prev_data = '0;

  int n_dv = 0, n_deser = 0, n_perr = 0, n_ferr = 0, n_strt = 0, n_par = 0, n_samp = 0, n_brk = 0;
  int b_dv, b_deser, b_perr, b_ferr, b_strt, b_par, b_samp, b_brk;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_rx_fsm #(.DATA_W(8), .PRESC_W(5), .BCNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .par_en      (par_en),
    .prescale    (prescale),
    .edge_count  (ec),
    .bit_count   (bcnt),
    .samp_bit    (samp_bit),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .cnt_en      (cnt_en),
    .cnt_clr     (cnt_clr),
    .samp_en     (samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
    .par_err_o   (par_err_o),
    .frame_err   (frame_err),
    .break_det   (break_det)
  );

  // Ideal sampler and checkers: line is held steady across each bit.
  assign samp_bit    = rx_in;
  assign strt_glitch = samp_bit;
  assign stp_err     = ~samp_bit;
  assign par_err     = (^shreg) ^ samp_bit;

  // Edge/bit counter and LSB-first deserializer driven by the DUT strobes.
  always @(posedge clk) begin
    if (cnt_clr) begin
      ec   <= '0;
      bcnt <= '0;
    end else if (cnt_en) begin
      if (ec == cur_presc) begin
        ec   <= '0;
        bcnt <= bcnt + 4'd1;
      end else begin
        ec <= ec + 5'd1;
      end
    end
    if (deser_en) shreg <= {samp_bit, shreg[7:1]};
  end

  // Event counters, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (data_valid) begin
      n_dv++;
      prev_data = last_data;
      last_data = shreg;
    end
    if (deser_en)    n_deser++;
    if (par_err_o)   n_perr++;
    if (frame_err)   n_ferr++;
    if (strt_chk_en) n_strt++;
    if (par_chk_en)  n_par++;
    if (samp_en)     n_samp++;
    if (break_det)   n_brk++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_dv = n_dv; b_deser = n_deser; b_perr = n_perr; b_ferr = n_ferr;
    b_strt = n_strt; b_par = n_par; b_samp = n_samp; b_brk = n_brk;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting at a falling clock edge; line left high afterwards.
  task automatic send_frame(input logic [7:0] d, input logic use_par, input logic par_bit,
                            input logic stop_bit, input int stop_clks);
    int p;
    p = int'(cur_presc) + 1;
    rx_in = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (p) @(negedge clk);
    end
    if (use_par) begin
      rx_in = par_bit;
      repeat (p) @(negedge clk);
    end
    rx_in = stop_bit;
    repeat (stop_clks) @(negedge clk);
    rx_in = 1'b1;
  endtask

  function automatic logic [10:0] all_outs();
    return {cnt_en, cnt_clr, samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
            data_valid, par_err_o, frame_err, break_det};
  endfunction

  initial begin
    rst = 1'b0; rx_in = 1'b1; par_en = 1'b0; prescale = 5'd7;
    check("reset_outs_async", 32'(all_outs()), 32'd0);
    idle(3);
    check("reset_outs", 32'(all_outs()), 32'd0);
    rst = 1'b1;
    idle(1);
    check("idle_cnt_clr", 32'(cnt_clr), 32'd1);
    check("idle_cnt_en", 32'(cnt_en), 32'd0);
    idle(3);

    // 1: prescale 7, no parity, 0xA5; mid-frame config changes must be ignored.
    snap();
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8);
      begin idle(20); prescale = 5'd15; par_en = 1'b1; end
    join
    idle(4);
    prescale = 5'd7; par_en = 1'b0;
    check("t1_dv", n_dv - b_dv, 1);
    check("t1_deser", n_deser - b_deser, 8);
    check("t1_data", 32'(last_data), 32'hA5);
    check("t1_errs", (n_perr - b_perr) + (n_ferr - b_ferr), 0);
    check("t1_samp_cycles", n_samp - b_samp, 78);
    idle(2);

    // 2: prescale 15 with even parity, good then bad parity on 0x3C.
    prescale = 5'd15; par_en = 1'b1; cur_presc = 5'd15;
    idle(2);
    snap();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16);
    idle(4);
    check("t2_good_dv", n_dv - b_dv, 1);
    check("t2_good_data", 32'(last_data), 32'h3C);
    check("t2_good_perr", n_perr - b_perr, 0);
    snap();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16);
    idle(4);
    check("t2_bad_perr", n_perr - b_perr, 1);
    check("t2_bad_dv", n_dv - b_dv, 0);
    check("t2_bad_par_chk", n_par - b_par, 1);
    check("t2_bad_ferr", n_ferr - b_ferr, 0);
    prescale = 5'd7; par_en = 1'b0; cur_presc = 5'd7;
    idle(3);

    // 3: two-cycle low glitch is rejected at the start vote.
    snap();
    rx_in = 1'b0;
    idle(2);
    rx_in = 1'b1;
    idle(12);
    check("t3_strt_chk", n_strt - b_strt, 1);
    check("t3_deser", n_deser - b_deser, 0);
    check("t3_dv", n_dv - b_dv, 0);
    check("t3_back_idle", 32'(cnt_clr), 32'd1);

    // 4a: 0x55 with low stop bit -> framing error only.
    snap();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 8);
    idle(4);
    check("t4_ferr", n_ferr - b_ferr, 1);
    check("t4_dv", n_dv - b_dv, 0);
    check("t4_brk", n_brk - b_brk, 0);

    // 4b: all-zero frame with low stop bit.
    snap();
`ifdef UART_RX_BREAK_DET_EN
    fork
      send_frame(8'h00, 1'b0, 1'b0, 1'b0, 16);
      begin idle(84); check("t4b_brk_hold", 32'(break_det), 32'd1); end
    join
    idle(3);
    check("t4b_brk_release", 32'(break_det), 32'd0);
    check("t4b_ferr", n_ferr - b_ferr, 0);
    check("t4b_dv", n_dv - b_dv, 0);
`else
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 8);
    idle(4);
    check("t4b_ferr", n_ferr - b_ferr, 1);
    check("t4b_brk", n_brk - b_brk, 0);
    check("t4b_dv", n_dv - b_dv, 0);
`endif
    idle(3);

    // 5: back-to-back frames with a single stop bit.
    snap();
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 8);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 8);
    idle(4);
    check("t5_dv", n_dv - b_dv, 2);
    check("t5_first", 32'(prev_data), 32'h01);
    check("t5_second", 32'(last_data), 32'hFE);
    check("t5_ferr", n_ferr - b_ferr, 0);

    // 6: reset during data bit 4 aborts the frame; the next frame is clean.
    snap();
    fork
      send_frame(8'hF8, 1'b0, 1'b0, 1'b1, 8);
      begin
        for (int i = 0; i < 200 && !(bcnt == 4'd4 && ec == 5'd2); i++) @(negedge clk);
        check("t6_reach_bit4", {23'd0, bcnt, ec}, {23'd0, 4'd4, 5'd2});
        rst = 1'b0;
        idle(1);
        check("t6_rst_outs", 32'(all_outs()), 32'd0);
        rst = 1'b1;
        idle(1);
        check("t6_idle_clr", 32'(cnt_clr), 32'd1);
      end
    join
    idle(4);
    check("t6_abort_dv", n_dv - b_dv, 0);
    snap();
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 8);
    idle(4);
    check("t6_next_dv", n_dv - b_dv, 1);
    check("t6_next_data", 32'(last_data), 32'h81);
    check("t6_next_deser", n_deser - b_deser, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
